stack_seq: RTL and testbench

- Sequencer directly upstream of the 4-deep bit-serial subroutine stack.
- Converts single-cycle call/return requests from the core decoder into clean, non-overlapping push (bsr) and pop (ret) strobes for the stack.
- Drives the push data bit, samples the popped bit and tracks stack depth with sticky overflow/underflow flags.
- After every reset it flushes the stack, which has no reset of its own.

---
 rtl/stack_seq_if.sv | 25 ++
 rtl/stack_seq.sv | 143 ++++++++++++++
 tb/tb_stack_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_seq_if.sv
// Core-side request/response bundle of the subroutine-stack sequencer.
interface stack_seq_if #(
  parameter int unsigned DEPTH_W = 3
);
  logic               call_req;
  logic               ret_req;
  logic               push_bit;
  logic               clr_err;
  logic               ready;
  logic               done;
  logic               pop_bit;
  logic [DEPTH_W-1:0] depth;
  logic               ovf;
  logic               unf;

  modport master (
    output call_req, ret_req, push_bit, clr_err,
    input  ready, done, pop_bit, depth, ovf, unf
  );

  modport slave (
    input  call_req, ret_req, push_bit, clr_err,
    output ready, done, pop_bit, depth, ovf, unf
  );
endinterface

// File: rtl/stack_seq.sv
// Turns single-cycle call/return requests into non-overlapping bsr/ret strobes
// for the bit-serial stack, tracks depth, and flushes the stack after reset.
module stack_seq #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned DEPTH_W = 3,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rstn,
  stack_seq_if.slave cpu,
  output logic       bsr,
  output logic       ret,
  output logic       stk_in,
  input  logic       stk_lifo
);

  typedef enum logic [2:0] {
    FLUSH_HI, FLUSH_LO, IDLE, PUSH_HI, PUSH_LO, POP_HI, POP_LO
  } state_t;

  localparam logic [CNT_W-1:0]   PH_LAST   = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0]   FL_LAST   = CNT_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   fcnt, fcnt_n;
  logic               phase_end, accept_push, accept_pop;
  logic               ready_n, done_n, bsr_n, ret_n, stk_in_n, pop_bit_n;
  logic               ovf_n, unf_n;
  logic [DEPTH_W-1:0] depth_n;

  assign phase_end   = (cnt == PH_LAST);
  assign accept_push = (state == IDLE) && cpu.call_req;
  assign accept_pop  = (state == IDLE) && !cpu.call_req && cpu.ret_req;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= FLUSH_HI;
      cnt         <= '0;
      fcnt        <= '0;
      cpu.ready   <= 1'b0;
      cpu.done    <= 1'b0;
      cpu.pop_bit <= 1'b0;
      cpu.depth   <= '0;
      cpu.ovf     <= 1'b0;
      cpu.unf     <= 1'b0;
      bsr         <= 1'b0;
      ret         <= 1'b0;
      stk_in      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      fcnt        <= fcnt_n;
      cpu.ready   <= ready_n;
      cpu.done    <= done_n;
      cpu.pop_bit <= pop_bit_n;
      cpu.depth   <= depth_n;
      cpu.ovf     <= ovf_n;
      cpu.unf     <= unf_n;
      bsr         <= bsr_n;
      ret         <= ret_n;
      stk_in      <= stk_in_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fcnt_n  = fcnt;
    case (state)
      FLUSH_HI: begin
        // Reset leaves ret low; the first edge only raises it, so every
        // flush pulse, including the first, is PULSE_W cycles wide.
        if (!ret) begin
          cnt_n = '0;
        end else if (phase_end) begin
          state_n = FLUSH_LO;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      FLUSH_LO: begin
        if (phase_end) begin
          cnt_n = '0;
          if (fcnt == FL_LAST) begin
            state_n = IDLE;
            fcnt_n  = '0;
          end else begin
            state_n = FLUSH_HI;
            fcnt_n  = fcnt + CNT_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      IDLE: begin
        cnt_n = '0;
        if (accept_push)     state_n = PUSH_HI;
        else if (accept_pop) state_n = POP_HI;
      end
      PUSH_HI, POP_HI, PUSH_LO, POP_LO: begin
        if (phase_end) begin
          cnt_n = '0;
          case (state)
            PUSH_HI: state_n = PUSH_LO;
            POP_HI:  state_n = POP_LO;
            default: state_n = IDLE;
          endcase
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = FLUSH_HI;
        cnt_n   = '0;
        fcnt_n  = '0;
      end
    endcase
  end

  always_comb begin
    ready_n   = (state_n == IDLE);
    done_n    = ((state == PUSH_LO) || (state == POP_LO)) && (state_n == IDLE);
    bsr_n     = (state_n == PUSH_HI);
    ret_n     = (state_n == FLUSH_HI) || (state_n == POP_HI);
    stk_in_n  = accept_push ? cpu.push_bit : stk_in;
    pop_bit_n = ((state == POP_HI) && (state_n == POP_LO)) ? stk_lifo : cpu.pop_bit;
    depth_n   = cpu.depth;
    ovf_n     = cpu.clr_err ? 1'b0 : cpu.ovf;
    unf_n     = cpu.clr_err ? 1'b0 : cpu.unf;
    if (accept_push) begin
      if (cpu.depth == DEPTH_MAX) ovf_n   = 1'b1;
      else                        depth_n = cpu.depth + DEPTH_W'(1);
    end else if (accept_pop) begin
      if (cpu.depth == '0) unf_n   = 1'b1;
      else                 depth_n = cpu.depth - DEPTH_W'(1);
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Scoreboard bench for stack_seq with a behavioural 4-deep bit-serial stack.
module tb_stack_seq;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PULSE_W = 2;
  localparam int unsigned DEPTH_W = 3;
  localparam int unsigned CNT_W   = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic bsr, ret, stk_in, stk_lifo;

  stack_seq_if #(.DEPTH_W(DEPTH_W)) bus ();

  stack_seq #(.DEPTH(DEPTH), .PULSE_W(PULSE_W), .DEPTH_W(DEPTH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .cpu(bus),
    .bsr(bsr), .ret(ret), .stk_in(stk_in), .stk_lifo(stk_lifo)
  );

  always #5 clk = ~clk;

  // Stack model: starts with garbage, acts on strobe rising edges.
  logic [DEPTH-1:0] cells = 4'b1011;
  logic lifo  = 1'b1;
  logic bsr_q = 1'b0;
  logic ret_q = 1'b0;
  always @(posedge clk) begin
    bsr_q <= bsr;
    ret_q <= ret;
    if (bsr && !bsr_q) cells <= {cells[DEPTH-2:0], stk_in};
    else if (ret && !ret_q) begin
      lifo  <= cells[0];
      cells <= {1'b0, cells[DEPTH-1:1]};
    end
  end
  assign stk_lifo = lifo;

  typedef struct {
    bit is_pop;
    bit pbit;
    int dep;
    bit ovf;
    bit unf;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int bsr_cnt = 0, ret_cnt = 0, overlap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bsr) bsr_cnt++;
    if (ret) ret_cnt++;
    if (bsr && ret) overlap++;
  end

  function automatic void chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc, mon_e.cyc);
        chk("ready_with_done", int'(bus.ready), 1);
        chk("depth", int'(bus.depth), mon_e.dep);
        chk("ovf", int'(bus.ovf), int'(mon_e.ovf));
        chk("unf", int'(bus.unf), int'(mon_e.unf));
        if (mon_e.is_pop) chk("pop_bit", int'(bus.pop_bit), int'(mon_e.pbit));
      end
    end
  end

  task automatic issue(input bit c, input bit r, input bit pb, input bit clr, input bit qexp,
                       input bit e_pop, input bit e_pb, input int e_dep,
                       input bit e_ovf, input bit e_unf);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      chk("ready_timeout", int'(bus.ready), 1);
      return;
    end
    bus.call_req = c;
    bus.ret_req  = r;
    bus.push_bit = pb;
    bus.clr_err  = clr;
    if (qexp) begin
      e = '{is_pop: e_pop, pbit: e_pb, dep: e_dep, ovf: e_ovf, unf: e_unf, cyc: cyc + 5};
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.call_req = 1'b0;
    bus.ret_req  = 1'b0;
    bus.push_bit = 1'b0;
    bus.clr_err  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(bus.ready && sb.size() == 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 0, 1);
  endtask

  task automatic flush_check();
    int rises = 0, rhi = 0, bhi = 0, dhi = 0, n = 0, start;
    bit prev = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(bus.ready), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_bsr", int'(bsr), 0);
    chk("rst_ret", int'(ret), 0);
    chk("rst_depth", int'(bus.depth), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    chk("rst_unf", int'(bus.unf), 0);
    chk("rst_pop_bit", int'(bus.pop_bit), 0);
    chk("rst_stk_in", int'(stk_in), 0);
    rstn  = 1'b1;
    start = cyc;
    do begin
      @(negedge clk);
      n++;
      if (ret && !prev) rises++;
      if (ret) rhi++;
      if (bsr) bhi++;
      if (bus.done) dhi++;
      prev = ret;
    end while (!bus.ready && n < 60);
    chk("flush_ready_cycle", cyc - start, 21);
    chk("flush_ret_pulses", rises, 5);
    chk("flush_ret_high_cycles", rhi, 10);
    chk("flush_bsr_high", bhi, 0);
    chk("flush_done", dhi, 0);
    chk("flush_depth", int'(bus.depth), 0);
    chk("flush_pop_bit", int'(bus.pop_bit), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, r0;
    bus.call_req = 1'b0;
    bus.ret_req  = 1'b0;
    bus.push_bit = 1'b0;
    bus.clr_err  = 1'b0;
    @(negedge clk);
    flush_check();

    // push 1,0,1 then pop three times
    issue(1, 0, 1, 0, 1, 0, 0, 1, 0, 0);
    issue(1, 0, 0, 0, 1, 0, 0, 2, 0, 0);
    issue(1, 0, 1, 0, 1, 0, 0, 3, 0, 0);
    issue(0, 1, 0, 0, 1, 1, 1, 2, 0, 0);
    issue(0, 1, 0, 0, 1, 1, 0, 1, 0, 0);
    issue(0, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    wait_idle();

    // simultaneous call/ret: push wins; ret_req while busy is ignored
    b0 = bsr_cnt;
    r0 = ret_cnt;
    issue(1, 1, 1, 0, 1, 0, 0, 1, 0, 0);
    @(negedge clk);
    bus.ret_req = 1'b1;
    @(negedge clk);
    bus.ret_req = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    chk("both_req_bsr_cycles", bsr_cnt - b0, 2);
    chk("both_req_ret_cycles", ret_cnt - r0, 0);
    chk("busy_ret_ignored_depth", int'(bus.depth), 1);
    issue(0, 1, 0, 0, 1, 1, 1, 0, 0, 0);

    // overflow: five pushes from empty
    issue(1, 0, 1, 0, 1, 0, 0, 1, 0, 0);
    issue(1, 0, 1, 0, 1, 0, 0, 2, 0, 0);
    issue(1, 0, 1, 0, 1, 0, 0, 3, 0, 0);
    issue(1, 0, 1, 0, 1, 0, 0, 4, 0, 0);
    issue(1, 0, 1, 0, 1, 0, 0, 4, 1, 0);
    wait_idle();
    bus.clr_err = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_err = 1'b0;
    @(negedge clk);
    chk("clr_ovf", int'(bus.ovf), 0);
    chk("clr_depth_held", int'(bus.depth), 4);
    // set beats clear in the same cycle
    issue(1, 0, 1, 1, 1, 0, 0, 4, 1, 0);
    wait_idle();

    // reset during PUSH_HI: strobe cut, no done, full flush
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bsr_before_cut", int'(bsr), 1);
    flush_check();
    repeat (3) @(negedge clk);

    // pop on empty after flush
    issue(0, 1, 0, 0, 1, 1, 0, 0, 0, 1);
    wait_idle();
    bus.clr_err = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_err = 1'b0;
    @(negedge clk);
    chk("clr_unf", int'(bus.unf), 0);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("bsr_ret_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
